// File: rtl/image_filter_engine.sv
// image_filter_engine: 3x3 neighbourhood filter (copy / median / mean) that scans a
// source frame in sync-read RAM and writes one filtered frame to a destination RAM.
// Median results come from an external MEDIAN core fed one pixel per cycle.
// Optional mean path: define FILTER_MEAN_EN to build it; without it MODE=2 acts as copy.
//
// state      | meaning
// IDLE       | after reset, waiting for START
// CLASSIFY   | decide copy (border or copy mode) vs windowed filter for pixel p
// RD1        | single source read of p
// FETCH      | 9 window reads, data captured one cycle later (10 cycles)
// WAIT_MED   | waiting for MEDIAN result strobe
// SUM        | scale accumulated window sum to the mean
// WRITE      | register destination write for p
// NEXT       | write pulse on the bus, advance pixel counter
// DONE       | frame complete, source/destination addresses follow VGA_ADDR
module image_filter_engine #(
   parameter int D_WIDTH = 8,
   parameter int W_LOG2  = 8,
   parameter int H_LOG2  = 8,
   parameter int A_WIDTH = W_LOG2 + H_LOG2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic [1:0]         MODE,
   output logic               BUSY,
   output logic               DONE,
   input  logic [A_WIDTH-1:0] VGA_ADDR,
   output logic [A_WIDTH-1:0] SRC_ADDR,
   input  logic [D_WIDTH-1:0] SRC_RDATA,
   output logic [A_WIDTH-1:0] DST_ADDR,
   output logic [D_WIDTH-1:0] DST_WDATA,
   output logic               DST_WE,
   output logic [D_WIDTH-1:0] MED_DI,
   output logic               MED_DSI,
   input  logic [D_WIDTH-1:0] MED_DO,
   input  logic               MED_DSO
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLASSIFY, S_RD1, S_FETCH, S_WAIT_MED, S_SUM, S_WRITE, S_NEXT, S_DONE
   } state_t;

   localparam logic [A_WIDTH-1:0] W_A   = A_WIDTH'(1) << W_LOG2;
   localparam logic [A_WIDTH-1:0] ONE_A = A_WIDTH'(1);

   state_t               state;
   logic [A_WIDTH-1:0]   pix;
   logic [A_WIDTH-1:0]   src_addr_q;
   logic [A_WIDTH-1:0]   dst_addr_q;
   logic [A_WIDTH-1:0]   win_addr;
   logic [D_WIDTH-1:0]   result_q;
   logic [D_WIDTH-1:0]   wdata_q;
   logic [3:0]           tap;
   logic [3:0]           tap_nxt;
   logic                 mode_med;
   logic                 mode_mean;
   logic                 busy_q;
   logic                 done_q;
   logic                 we_q;
   logic                 dsi_q;
   logic                 border;
   logic                 use_copy;
   logic [H_LOG2-1:0]    row;
   logic [W_LOG2-1:0]    col;

   assign row      = pix[A_WIDTH-1:W_LOG2];
   assign col      = pix[W_LOG2-1:0];
   assign border   = (row == '0) || (row == '1) || (col == '0) || (col == '1);
   assign use_copy = border || !(mode_med || mode_mean);

`ifdef FILTER_MEAN_EN
   logic [D_WIDTH+3:0]  sum_q;
   logic [D_WIDTH+12:0] prod;
   logic [D_WIDTH+12:0] scaled;
   logic [D_WIDTH-1:0]  mean_res;

   // 455/4096 approximates 1/9; saturate in case the scaled sum exceeds the pixel range
   always_comb begin
      prod     = (D_WIDTH+13)'(sum_q) * (D_WIDTH+13)'(455);
      scaled   = prod >> 12;
      mean_res = (scaled > (D_WIDTH+13)'({D_WIDTH{1'b1}})) ? '1 : scaled[D_WIDTH-1:0];
   end
`endif

   // window address for the next tap: CLASSIFY issues tap 0, FETCH issues tap+1
   always_comb begin
      tap_nxt  = (state == S_FETCH) ? tap + 4'd1 : 4'd0;
      win_addr = pix;
      case (tap_nxt)
         4'd0:    win_addr = pix - W_A - ONE_A;
         4'd1:    win_addr = pix - W_A;
         4'd2:    win_addr = pix - W_A + ONE_A;
         4'd3:    win_addr = pix - ONE_A;
         4'd4:    win_addr = pix + ONE_A;
         4'd5:    win_addr = pix + W_A - ONE_A;
         4'd6:    win_addr = pix + W_A;
         4'd7:    win_addr = pix + W_A + ONE_A;
         default: win_addr = pix;
      endcase
   end

   // sequencer with registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         pix        <= '0;
         src_addr_q <= '0;
         dst_addr_q <= '0;
         result_q   <= '0;
         wdata_q    <= '0;
         tap        <= '0;
         mode_med   <= 1'b0;
         mode_mean  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
         dsi_q      <= 1'b0;
`ifdef FILTER_MEAN_EN
         sum_q      <= '0;
`endif
      end else begin
         we_q  <= 1'b0;
         dsi_q <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (START) begin
                  mode_med <= (MODE == 2'd1);
`ifdef FILTER_MEAN_EN
                  mode_mean <= (MODE == 2'd2);
`else
                  mode_mean <= 1'b0;
`endif
                  pix    <= '0;
                  busy_q <= 1'b1;
                  done_q <= 1'b0;
                  state  <= S_CLASSIFY;
               end
            end
            S_CLASSIFY: begin
               tap <= '0;
`ifdef FILTER_MEAN_EN
               sum_q <= '0;
`endif
               if (use_copy) begin
                  src_addr_q <= pix;
                  state      <= S_RD1;
               end else begin
                  src_addr_q <= win_addr;
                  state      <= S_FETCH;
               end
            end
            S_RD1: state <= S_WRITE;
            S_FETCH: begin
               tap <= tap_nxt;
`ifdef FILTER_MEAN_EN
               if (tap != 4'd0) sum_q <= sum_q + (D_WIDTH+4)'(SRC_RDATA);
`endif
               if (tap < 4'd8) src_addr_q <= win_addr;
               dsi_q <= mode_med && (tap <= 4'd8);
               if (tap == 4'd9) state <= mode_med ? S_WAIT_MED : S_SUM;
            end
            S_WAIT_MED: begin
               if (MED_DSO) begin
                  result_q <= MED_DO;
                  state    <= S_WRITE;
               end
            end
            S_SUM: begin
`ifdef FILTER_MEAN_EN
               result_q <= mean_res;
`endif
               state <= S_WRITE;
            end
            S_WRITE: begin
               we_q       <= 1'b1;
               dst_addr_q <= pix;
               wdata_q    <= use_copy ? SRC_RDATA : result_q;
               state      <= S_NEXT;
            end
            S_NEXT: begin
               pix <= pix + ONE_A;
               if (pix == '1) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  state <= S_CLASSIFY;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign DST_WE    = we_q;
   assign DST_WDATA = wdata_q;
   assign MED_DSI   = dsi_q;
   assign MED_DI    = SRC_RDATA;
   assign SRC_ADDR  = done_q ? VGA_ADDR : src_addr_q;
   assign DST_ADDR  = done_q ? VGA_ADDR : dst_addr_q;

endmodule

// File: tb/tb_image_filter_engine.sv
// Bench for image_filter_engine on an 8x8 frame with sync-read RAM and MEDIAN models.
module tb_image_filter_engine;

   localparam int DW = 8;
   localparam int AW = 6;
`ifdef FILTER_MEAN_EN
   localparam bit MEAN_ON = 1'b1;
`else
   localparam bit MEAN_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    mode;
   logic          busy, done;
   logic [AW-1:0] vga_addr;
   logic [AW-1:0] src_addr, dst_addr;
   logic [DW-1:0] src_rdata, dst_wdata;
   logic          dst_we;
   logic [DW-1:0] med_di, med_do;
   logic          med_dsi, med_dso;

   logic [DW-1:0] src_mem [64];
   logic [DW-1:0] dst_mem [64];

   int n_checks = 0;
   int n_fail   = 0;
   int wr_count = 0;
   int dsi_count = 0;
   logic [AW-1:0] exp_addr_q [$];
   logic [DW-1:0] exp_data_q [$];

   always #5 clk = ~clk;

   image_filter_engine #(.D_WIDTH(DW), .W_LOG2(3), .H_LOG2(3)) dut (
      .CLK(clk), .RST(rst), .START(start), .MODE(mode), .BUSY(busy), .DONE(done),
      .VGA_ADDR(vga_addr), .SRC_ADDR(src_addr), .SRC_RDATA(src_rdata),
      .DST_ADDR(dst_addr), .DST_WDATA(dst_wdata), .DST_WE(dst_we),
      .MED_DI(med_di), .MED_DSI(med_dsi), .MED_DO(med_do), .MED_DSO(med_dso)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int median9(input int v[9]);
      int a[9];
      int t;
      a = v;
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      return a[4];
   endfunction

   function automatic int ref_pix(input int m, input int i);
      int r, c, s;
      int w[9];
      r = i >> 3;
      c = i & 7;
      if (r == 0 || r == 7 || c == 0 || c == 7) return int'(src_mem[i]);
      w[0] = src_mem[i-9]; w[1] = src_mem[i-8]; w[2] = src_mem[i-7];
      w[3] = src_mem[i-1]; w[4] = src_mem[i+1]; w[5] = src_mem[i+7];
      w[6] = src_mem[i+8]; w[7] = src_mem[i+9]; w[8] = src_mem[i];
      if (m == 1) return median9(w);
      if (m == 2 && MEAN_ON) begin
         s = 0;
         for (int k = 0; k < 9; k++) s += w[k];
         s = (s * 455) >> 12;
         return (s > 255) ? 255 : s;
      end
      return int'(src_mem[i]);
   endfunction

   // sync-read source RAM and write-only destination RAM
   always @(posedge clk) begin
      src_rdata <= src_mem[src_addr];
      if (dst_we) dst_mem[dst_addr] <= dst_wdata;
   end

   // MEDIAN core model: collects 9 strobed pixels, pulses the median one cycle later
   int med_buf [9];
   int med_cnt = 0;
   always @(posedge clk) begin
      med_dso <= 1'b0;
      if (med_dsi) begin
         med_buf[med_cnt] = int'(med_di);
         med_cnt++;
         if (med_cnt == 9) begin
            med_do  <= DW'(median9(med_buf));
            med_dso <= 1'b1;
            med_cnt = 0;
         end
      end
   end

   // scoreboard monitor for destination writes
   always @(negedge clk) begin
      if (!rst && dst_we) begin
         wr_count++;
         if (exp_addr_q.size() == 0) check("wr_unexpected", 1, 0);
         else begin
            check("wr_addr", dst_addr, exp_addr_q.pop_front());
            check("wr_data", dst_wdata, exp_data_q.pop_front());
         end
      end
      if (!rst && med_dsi) dsi_count++;
   end

   task automatic run_frame(input int m, input bit mid_start);
      int cyc;
      for (int i = 0; i < 64; i++) begin
         dst_mem[i] = 8'hEE;
         exp_addr_q.push_back(AW'(i));
         exp_data_q.push_back(DW'(ref_pix(m, i)));
      end
      wr_count  = 0;
      dsi_count = 0;
      @(negedge clk);
      mode  = 2'(m);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      cyc = 0;
      while (!done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (mid_start && cyc == 50) start = 1'b1;
         if (mid_start && cyc == 51) start = 1'b0;
      end
      check("done_seen", done, 1);
      check("busy_at_done", busy, 0);
      check("write_count", wr_count, 64);
      check("queue_drained", exp_addr_q.size(), 0);
   endtask

   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; mode = 2'd0; vga_addr = '0; med_do = '0; med_dso = 1'b0;
      for (int i = 0; i < 64; i++) src_mem[i] = DW'(i);
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_we", dst_we, 0);
      check("rst_dsi", med_dsi, 0);
      check("rst_src_addr", src_addr, 0);
      check("rst_dst_addr", dst_addr, 0);
      @(negedge clk);
      rst = 1'b0;

      // copy with a START pulse mid-frame that must be ignored
      run_frame(0, 1'b1);
      for (int i = 0; i < 64; i += 9) check("copy_dst", dst_mem[i], i);
      check("copy_dst_63", dst_mem[63], 63);

      // display hand-over
      vga_addr = 6'h2A;
      #1;
      check("vga_src_addr", src_addr, 6'h2A);
      check("vga_dst_addr", dst_addr, 6'h2A);
      check("vga_we", dst_we, 0);
      repeat (3) @(negedge clk);
      check("vga_we_hold", dst_we, 0);

      // median with a single hot pixel
      for (int i = 0; i < 64; i++) src_mem[i] = 8'd10;
      src_mem[27] = 8'd200;
      run_frame(1, 1'b0);
      check("med_dst_27", dst_mem[27], 10);
      check("med_border_0", dst_mem[0], 10);
      check("med_border_63", dst_mem[63], 10);
      check("med_dsi_count", dsi_count, 324);

      // mean of a flat frame
      for (int i = 0; i < 64; i++) src_mem[i] = 8'd90;
      run_frame(2, 1'b0);
      check("mean_dst_9", dst_mem[9], MEAN_ON ? 89 : 90);
      check("mean_dst_54", dst_mem[54], MEAN_ON ? 89 : 90);
      check("mean_border_7", dst_mem[7], 90);

      // reset mid-frame at pixel 20
      for (int i = 0; i < 64; i++) src_mem[i] = DW'(i);
      for (int i = 0; i < 64; i++) begin
         exp_addr_q.push_back(AW'(i));
         exp_data_q.push_back(DW'(i));
      end
      wr_count = 0;
      @(negedge clk);
      mode = 2'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (wr_count < 20 && cyc < 2000) begin
         @(posedge clk);
         cyc++;
      end
      check("reached_pixel_20", wr_count >= 20, 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_we", dst_we, 0);
      check("midrst_dsi", med_dsi, 0);
      check("midrst_src_addr", src_addr, 0);
      check("midrst_dst_addr", dst_addr, 0);
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
